// File: rtl/shift_seq_pkg.sv
// ---------------------------------------------------------------------------
// shift_seq_pkg -- shared types and constants for the shift_seq_ctrl slice.
//
// Contents:
//   state_t        : controller FSM state encoding (IDLE/SHIFT/PAR/DONE)
//   DEFAULT_WIDTH  : default serial word length in bits
//
// Optional feature macro (used by shift_seq_ctrl): SHIFT_SEQ_PARITY_EN
// ---------------------------------------------------------------------------
package shift_seq_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // PAR is only ever entered when the parity feature is compiled in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : shift_seq_pkg

// File: rtl/shift_seq_ctrl_core.sv
// ---------------------------------------------------------------------------
// shift_core -- parallel-load shift register datapath.
//
// Parameters:
//   WIDTH     : register width in bits
//   MSB_FIRST : 1 = head is bit WIDTH-1 and data moves toward the MSB,
//               0 = head is bit 0 and data moves toward the LSB
// Ports:
//   clk        : clock, posedge
//   rst_n      : asynchronous active-low clear (register -> 0)
//   load       : load load_data (has priority over shift_en)
//   load_data  : parallel word
//   shift_en   : advance the register by one bit, zero fill
//   head       : bit currently at the output end of the register
// ---------------------------------------------------------------------------
module shift_core #(
    parameter int WIDTH     = shift_seq_pkg::DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             head
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;

    // Per-bit next-state: each bit takes its upstream neighbour on a shift,
    // the far end fills with zero.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic shift_in;
            if (MSB_FIRST != 0) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign shift_in = 1'b0;
                end else begin : g_link
                    assign shift_in = data_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_fill
                    assign shift_in = 1'b0;
                end else begin : g_link
                    assign shift_in = data_reg[gi+1];
                end
            end
            assign data_next[gi] = load     ? load_data[gi] :
                                   shift_en ? shift_in      : data_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
        end else begin
            data_reg <= data_next;
        end
    end

    assign head = (MSB_FIRST != 0) ? data_reg[WIDTH-1] : data_reg[0];

endmodule : shift_core

// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl -- parallel-to-serial controller with ready/valid on both
// sides. Accepts a word in IDLE, shifts it out one bit per so_ready, then
// pulses done for one cycle before returning to IDLE.
//
// Parameters:
//   WIDTH     : serial word length, 2..32
//   MSB_FIRST : 1 = in_data[WIDTH-1] first, 0 = in_data[0] first
// Ports:
//   clk, rst_n          : clock (posedge), async active-low reset
//   in_valid/in_ready   : parallel word handshake, in_data = word
//   so/so_valid/so_ready: serial bit handshake
//   busy                : frame in progress (SHIFT, PAR, DONE)
//   done                : one-cycle pulse after the last bit is consumed
//
// Optional feature macro: SHIFT_SEQ_PARITY_EN -- appends one even-parity bit
// (XOR of the loaded word) after the data bits, same so_ready handshake.
// ---------------------------------------------------------------------------
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             so,
    output logic             so_valid,
    input  logic             so_ready,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             so_valid_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             in_ready_reg;
    logic             accept;
    logic             shift_en;
    logic             head;
`ifdef SHIFT_SEQ_PARITY_EN
    logic             parity_reg;
`endif

    assign accept   = (state_reg == IDLE) && in_valid && in_ready_reg;
    assign shift_en = (state_reg == SHIFT) && so_ready;

    shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data (in_data),
        .shift_en  (shift_en),
        .head      (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            so_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            in_ready_reg <= 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // in_ready rises on the first clock after reset release.
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        state_reg    <= SHIFT;
                        cnt_reg      <= '0;
                        so_valid_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        in_ready_reg <= 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
                        parity_reg   <= ^in_data;
`endif
                    end
                end
                SHIFT: begin
                    if (so_ready) begin
                        // Counter stops at WIDTH at most, which still fits.
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == LAST_CNT) begin
`ifdef SHIFT_SEQ_PARITY_EN
                            state_reg    <= PAR;
`else
                            state_reg    <= DONE;
                            so_valid_reg <= 1'b0;
                            done_reg     <= 1'b1;
`endif
                        end
                    end
                end
`ifdef SHIFT_SEQ_PARITY_EN
                PAR: begin
                    if (so_ready) begin
                        state_reg    <= DONE;
                        so_valid_reg <= 1'b0;
                        done_reg     <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    // in_ready stays low this cycle, so no word is taken here.
                    state_reg    <= IDLE;
                    busy_reg     <= 1'b0;
                    in_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg    <= IDLE;
                    so_valid_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    in_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // so is a pure function of registers; it is forced low outside the
    // bit-carrying states so it is 0 whenever so_valid is 0.
    always_comb begin
        so = 1'b0;
        if (state_reg == SHIFT) begin
            so = head;
        end
`ifdef SHIFT_SEQ_PARITY_EN
        else if (state_reg == PAR) begin
            so = parity_reg;
        end
`endif
    end

    assign so_valid = so_valid_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign in_ready = in_ready_reg;

endmodule : shift_seq_ctrl

// File: tb/tb_shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_ctrl -- directed, table-driven bench for shift_seq_ctrl.
// Two instances: u_msb (MSB_FIRST=1) and u_lsb (MSB_FIRST=0), WIDTH=8.
// Honours SHIFT_SEQ_PARITY_EN (frames carry a ninth parity bit).
// ---------------------------------------------------------------------------
module tb_shift_seq_ctrl;

`ifdef SHIFT_SEQ_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid_m = 1'b0;
    logic       in_valid_l = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       so_ready = 1'b0;

    logic in_ready_m, so_m, so_valid_m, busy_m, done_m;
    logic in_ready_l, so_l, so_valid_l, busy_l, done_l;

    logic sel = 1'b0;  // 0 = MSB-first instance, 1 = LSB-first instance
    logic cur_in_ready, cur_so, cur_so_valid, cur_busy, cur_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_m), .in_ready(in_ready_m), .in_data(in_data),
        .so(so_m), .so_valid(so_valid_m), .so_ready(so_ready),
        .busy(busy_m), .done(done_m)
    );

    shift_seq_ctrl #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_l), .in_ready(in_ready_l), .in_data(in_data),
        .so(so_l), .so_valid(so_valid_l), .so_ready(so_ready),
        .busy(busy_l), .done(done_l)
    );

    assign cur_in_ready = sel ? in_ready_l : in_ready_m;
    assign cur_so       = sel ? so_l       : so_m;
    assign cur_so_valid = sel ? so_valid_l : so_valid_m;
    assign cur_busy     = sel ? busy_l     : busy_m;
    assign cur_done     = sel ? done_l     : done_m;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // seq holds the data bits in transmit order, first bit at seq[7].
    function automatic logic exp_bit(input logic [7:0] seq, input logic par, input int k);
        return (k < 8) ? seq[7-k] : par;
    endfunction

    // Called at a negedge with the controller idle; returns at the negedge
    // after the accepting posedge (first bit visible).
    task automatic send(input logic [7:0] d);
        check("accept_in_ready", int'(cur_in_ready), 1);
        if (sel) in_valid_l = 1'b1; else in_valid_m = 1'b1;
        in_data = d;
        @(negedge clk);
        in_valid_m = 1'b0;
        in_valid_l = 1'b0;
    endtask

    // Consume nb bits; bit index stall_at is held stall_len cycles with
    // so_ready low. Checks every cycle and the count of so_valid cycles.
    task automatic consume(input logic [7:0] seq, input logic par, input int nb,
                           input int stall_at, input int stall_len, input int exp_len,
                           output int cyc);
        int k = 0;
        int stalled = 0;
        int guard = 0;
        cyc = 0;
        while (k < nb && guard < 64) begin
            guard++;
            cyc++;
            check("so_valid", int'(cur_so_valid), 1);
            check("so_bit", int'(cur_so), int'(exp_bit(seq, par, k)));
            check("busy_in_frame", int'(cur_busy), 1);
            check("in_ready_in_frame", int'(cur_in_ready), 0);
            check("done_in_frame", int'(cur_done), 0);
            if (k == stall_at && stalled < stall_len) begin
                so_ready = 1'b0;
                stalled++;
            end else begin
                so_ready = 1'b1;
                k++;
            end
            @(negedge clk);
        end
        check("frame_len", cyc, exp_len);
    endtask

    // DONE cycle then first IDLE cycle.
    task automatic tail();
        so_ready = 1'b0;
        check("done_pulse", int'(cur_done), 1);
        check("done_so_valid", int'(cur_so_valid), 0);
        check("done_so", int'(cur_so), 0);
        check("done_busy", int'(cur_busy), 1);
        check("done_in_ready", int'(cur_in_ready), 0);
        @(negedge clk);
        check("idle_done", int'(cur_done), 0);
        check("idle_busy", int'(cur_busy), 0);
        check("idle_in_ready", int'(cur_in_ready), 1);
    endtask

    typedef struct {
        logic       sel;
        logic [7:0] data;
        logic [7:0] seq;
        logic       par;
        int         stall_at;
        int         stall_len;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cyc;
        vecs[0] = '{1'b0, 8'hA5, 8'b10100101, 1'b0, -1, 0};
        vecs[1] = '{1'b1, 8'h01, 8'b10000000, 1'b1, -1, 0};
        vecs[2] = '{1'b0, 8'hF0, 8'b11110000, 1'b0,  2, 3};
        vecs[3] = '{1'b1, 8'h0B, 8'b11010000, 1'b1,  0, 2};
        vecs[4] = '{1'b0, 8'h0B, 8'b00001011, 1'b1,  7, 1};
        vecs[5] = '{1'b0, 8'h07, 8'b00000111, 1'b1, -1, 0};

        // Reset state, mid-reset.
        #12;
        check("rst_in_ready_m", int'(in_ready_m), 0);
        check("rst_so_valid_m", int'(so_valid_m), 0);
        check("rst_so_m", int'(so_m), 0);
        check("rst_busy_m", int'(busy_m), 0);
        check("rst_done_m", int'(done_m), 0);
        check("rst_in_ready_l", int'(in_ready_l), 0);
        check("rst_busy_l", int'(busy_l), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready_m", int'(in_ready_m), 1);
        check("post_rst_in_ready_l", int'(in_ready_l), 1);

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            sel = vecs[i].sel;
            send(vecs[i].data);
            consume(vecs[i].seq, vecs[i].par, NBITS, vecs[i].stall_at,
                    vecs[i].stall_len, NBITS + vecs[i].stall_len, cyc);
            tail();
            $display("frame %0d: data=%h lsb_first=%0d valid_cycles=%0d",
                     i, vecs[i].data, vecs[i].sel, cyc);
        end

        // Second word held on in_valid throughout a frame.
        sel = 1'b0;
        check("hold_in_ready", int'(cur_in_ready), 1);
        in_valid_m = 1'b1;
        in_data = 8'h5A;
        @(negedge clk);
        in_data = 8'h96;
        consume(8'h5A, 1'b0, NBITS, -1, 0, NBITS, cyc);
        check("hold_done_pulse", int'(cur_done), 1);
        check("hold_done_in_ready", int'(cur_in_ready), 0);
        @(negedge clk);
        check("hold_idle_busy", int'(cur_busy), 0);
        check("hold_idle_in_ready", int'(cur_in_ready), 1);
        @(negedge clk);
        in_valid_m = 1'b0;
        consume(8'h96, 1'b0, NBITS, -1, 0, NBITS, cyc);
        tail();
        $display("frame held: first=5a second=96 valid_cycles=%0d", cyc);

        // Reset in the middle of a frame.
        send(8'hC3);
        consume(8'hC3, 1'b0, 4, -1, 0, 4, cyc);
        #2 rst_n = 1'b0;
        #1;
        check("abort_so_valid", int'(so_valid_m), 0);
        check("abort_so", int'(so_m), 0);
        check("abort_busy", int'(busy_m), 0);
        check("abort_done", int'(done_m), 0);
        check("abort_in_ready", int'(in_ready_m), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_rel_done", int'(done_m), 0);
        @(negedge clk);
        check("abort_idle_in_ready", int'(in_ready_m), 1);
        check("abort_idle_done", int'(done_m), 0);
        send(8'h3C);
        consume(8'h3C, 1'b0, NBITS, -1, 0, NBITS, cyc);
        tail();
        $display("frame after abort: data=3c valid_cycles=%0d", cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_shift_seq_ctrl

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, serial word length in bits (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1, 1 = transmit in_data[WIDTH-1] first, 0 = in_data[0] first.
REQ-003 clk  input  1  single clock, all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  parallel word offered.
REQ-006 in_ready  output  1  controller can accept a word.
REQ-007 in_data  input  WIDTH  parallel word to serialise.
REQ-008 so  output  1  serial data bit.
REQ-009 so_valid  output  1  so carries a valid bit this cycle.
REQ-010 so_ready  input  1  downstream consumes so this cycle.
REQ-011 busy  output  1  a frame is in progress.
REQ-012 done  output  1  one-cycle pulse after the last bit is consumed.

Function
REQ-013 The FSM SHALL have exactly these states: IDLE, SHIFT, PAR, DONE.
REQ-014 The word SHALL be accepted when in_valid and in_ready are both high on a posedge; in_ready SHALL be high only in IDLE.
REQ-015 On accept: load in_data into the internal shift register, clear the bit counter, and enter SHIFT; so_valid SHALL rise in the next cycle.
REQ-016 In SHIFT: so_valid=1 and so=current head bit; the register shifts by one bit and the counter increments only when so_ready=1.
REQ-017 With so_ready=0, so, so_valid and the counter SHALL hold unchanged for any number of cycles.
REQ-018 When the bit with count WIDTH-1 is consumed: go to PAR if PARITY_EN is defined, otherwise to DONE.
REQ-019 In DONE: done=1 and so_valid=0 for exactly one cycle, then IDLE unconditionally.
REQ-020 busy SHALL equal 1 in SHIFT, PAR and DONE, and 0 in IDLE.
REQ-021 in_valid during busy SHALL be ignored; no word is lost or overwritten, and the upstream holds in_valid.
REQ-022 A new word SHALL NOT be accepted in the DONE cycle; the earliest re-accept is the cycle after DONE.
REQ-023 The counter SHALL be exactly $clog2(WIDTH+1) bits wide and SHALL NOT wrap within a frame.
REQ-024 so SHALL be 0 whenever so_valid=0.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, counter 0, shift register 0, so=0, so_valid=0, busy=0, done=0, and in_ready=0 while rst_n is low.
REQ-026 Reset mid-frame SHALL abort the frame without a done pulse; after release, in_ready=1 from the first posedge.

Configuration
REQ-027 Macro SHIFT_SEQ_PARITY_EN: when defined, the PAR state SHALL transmit one even-parity bit (XOR of the loaded word) with the same so_ready handshake, followed by DONE.
REQ-028 When SHIFT_SEQ_PARITY_EN is undefined, the PAR state and the parity logic SHALL be absent, and the frame is exactly WIDTH bits.

Structure
REQ-029 Package shift_seq_pkg SHALL hold the state enum type (IDLE/SHIFT/PAR/DONE) and the default WIDTH constant.
REQ-030 The datapath SHALL be a sub-module shift_core: parallel load, shift-enable, head-bit output, async active-low clear.
REQ-031 shift_seq_ctrl SHALL contain the FSM, counter, handshake and parity logic only.

Verification
REQ-032 WIDTH=8, MSB_FIRST=1, in_data=8'hA5, so_ready=1 -> so sequence 1,0,1,0,0,1,0,1 over 8 cycles, then done pulse, then in_ready=1.
REQ-033 MSB_FIRST=0, in_data=8'h01, so_ready=1 -> first so=1, then seven 0s.
REQ-034 in_data=8'hF0, so_ready low for 3 cycles after bit 2 -> so/so_valid are held 3 cycles, the sequence is otherwise unchanged, and total frame length is 11 cycles.
REQ-035 in_valid held high with a second word during the frame -> second word accepted only in the cycle after done, sent intact.
REQ-036 rst_n pulsed low after bit 4 of 8'hC3 -> outputs zero immediately, no done pulse, next word transmits correctly.
REQ-037 SHIFT_SEQ_PARITY_EN defined, in_data=8'h07 -> 9 bits transmitted, last bit=1, done follows bit 9.
